// File: rtl/encoder_8to3_pkg.sv
// Shared constants and state type for the 8:3 encoder serializer.
package encoder_8to3_pkg;

    localparam int WIDTH  = 8;
    localparam int CODE_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } enc_state_t;

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational lowest-set-bit priority encoder: index, found flag and one-hot mask.
module prio_enc_8to3
    import encoder_8to3_pkg::*;
(
    input  logic [WIDTH-1:0]  in,
    output logic [CODE_W-1:0] code,
    output logic              found,
    output logic [WIDTH-1:0]  onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        code  = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                code  = CODE_W'(i);
                found = 1'b1;
            end
        end
    end

    assign onehot = in & (~in + WIDTH'(1));

endmodule

// File: rtl/encoder_8to3_serializer.sv
// Serializes a multi-hot request vector into ascending 3-bit indices, one per handshaked beat.
module encoder_8to3_serializer
    import encoder_8to3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    output logic              out_none
);

    enc_state_t        state_q, state_d;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              last_q, last_d;
    logic              none_q, none_d;
    logic              valid_q, valid_d;

    logic [CODE_W-1:0] in_code, pend_code;
    logic              in_found, pend_found;
    logic [WIDTH-1:0]  in_onehot, pend_onehot;
    logic [WIDTH-1:0]  in_rest, pend_rest;

    prio_enc_8to3 u_enc_in (
        .in     (in_vec),
        .code   (in_code),
        .found  (in_found),
        .onehot (in_onehot)
    );

    prio_enc_8to3 u_enc_pend (
        .in     (pend_q),
        .code   (pend_code),
        .found  (pend_found),
        .onehot (pend_onehot)
    );

    assign in_rest   = in_vec & ~in_onehot;
    assign pend_rest = pend_q & ~pend_onehot;

    assign in_ready  = (state_q == IDLE) && enable && rst_n;
    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign out_last  = last_q;
    assign out_none  = none_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        code_d  = code_q;
        last_d  = last_q;
        none_d  = none_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = BUSY;
                    valid_d = 1'b1;
                    if (in_found) begin
                        code_d = in_code;
                        pend_d = in_rest;
                        last_d = (in_rest == '0);
                        none_d = 1'b0;
                    end else begin
                        // All-zero vector still produces a single marker beat.
                        code_d = '0;
                        pend_d = '0;
                        last_d = 1'b1;
                        none_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        pend_d  = '0;
                        code_d  = '0;
                        last_d  = 1'b0;
                        none_d  = 1'b0;
                    end else if (pend_found) begin
                        code_d = pend_code;
                        pend_d = pend_rest;
                        last_d = (pend_rest == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            last_q  <= 1'b0;
            none_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            last_q  <= last_d;
            none_q  <= none_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_encoder_8to3_serializer.sv
// Scenario-driven bench: expected beats are queued at accept and matched as the DUT emits them.
module tb_encoder_8to3_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic       out_last;
    logic       out_none;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic       none;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    fails  = 0;

    encoder_8to3_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_none  (out_none)
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshaked beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected: got code=%0d last=%0b none=%0b, required no beat",
                         out_code, out_last, out_none);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (out_code !== e.code || out_last !== e.last || out_none !== e.none) begin
                    fails++;
                    $display("FAIL scoreboard_beat: got code=%0d last=%0b none=%0b, required code=%0d last=%0b none=%0b",
                             out_code, out_last, out_none, e.code, e.last, e.none);
                end else begin
                    $display("beat code=%0d last=%0b none=%0b", out_code, out_last, out_none);
                end
            end
        end
    end

    task automatic push_expected(input logic [7:0] v);
        int idx[$];
        beat_t b;
        for (int i = 0; i < 8; i++) if (v[i]) idx.push_back(i);
        if (idx.size() == 0) begin
            b.code = 3'd0; b.last = 1'b1; b.none = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < idx.size(); k++) begin
                b.code = 3'(idx[k]);
                b.last = (k == idx.size() - 1);
                b.none = 1'b0;
                exp_q.push_back(b);
            end
        end
    endtask

    // Presents v until accepted; returns 1ns after the accepting edge.
    task automatic send(input logic [7:0] v);
        bit ok = 1'b0;
        in_vec   = v;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            push_expected(v);
            $display("accept in_vec=%02h", v);
        end else begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for vector %02h, required 1", v);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_code !== 3'd0) begin
                fails++;
                $display("FAIL reset_hold: out_valid=%0b in_ready=%0b out_code=%0d, required 0 0 0",
                         out_valid, in_ready, out_code);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_none !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b last=%0b none=%0b, required 1 0 0 0",
                     in_ready, out_valid, out_last, out_none);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_bit();
        out_ready = 1'b1;
        send(8'h20);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd5 || out_last !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_beat: valid=%0b code=%0d last=%0b in_ready=%0b, required 1 5 1 0",
                     out_valid, out_code, out_last, in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_return: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        wait_drain("single");
    endtask

    task automatic test_multi_hot();
        logic [2:0] codes [4];
        codes = '{3'd0, 3'd2, 3'd5, 3'd7};
        out_ready = 1'b1;
        send(8'hA5);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_code !== codes[k] || out_last !== (k == 3)) begin
                fails++;
                $display("FAIL multi_beat%0d: valid=%0b code=%0d last=%0b, required 1 %0d %0b",
                         k, out_valid, out_code, out_last, codes[k], (k == 3));
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL multi_end: out_valid=%0b, required 0", out_valid);
        end
        wait_drain("multi");
    endtask

    task automatic test_backpressure();
        logic       rdy  [5];
        logic [2:0] code [5];
        rdy  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        code = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
        out_ready = 1'b0;
        send(8'h81);
        for (int k = 0; k < 5; k++) begin
            out_ready = rdy[k];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_code !== code[k] || out_last !== (k >= 3)) begin
                fails++;
                $display("FAIL bp_cycle%0d: valid=%0b code=%0d last=%0b, required 1 %0d %0b",
                         k, out_valid, out_code, out_last, code[k], (k >= 3));
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_end: out_valid=%0b, required 0", out_valid);
        end
        wait_drain("bp");
    endtask

    task automatic test_zero_enable();
        out_ready = 1'b1;
        send(8'h00);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_none !== 1'b1 || out_code !== 3'd0 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL zero_beat: valid=%0b none=%0b code=%0d last=%0b, required 1 1 0 1",
                     out_valid, out_none, out_code, out_last);
        end
        wait_drain("zero");

        enable = 1'b0; in_valid = 1'b1; in_vec = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL enable_block%0d: in_ready=%0b out_valid=%0b, required 0 0",
                         i, in_ready, out_valid);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        enable   = 1'b1;

        send(8'hFF);
        enable = 1'b0;
        wait_drain("enable_mid");
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        send(8'hFF);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_quiet%0d: out_valid=%0b code=%0d, required out_valid 0",
                         i, out_valid, out_code);
            end
        end
        @(posedge clk);
        #1;
        send(8'h02);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd1 || out_last !== 1'b1) begin
            fails++;
            $display("FAIL midrst_accept: valid=%0b code=%0d last=%0b, required 1 1 1",
                     out_valid, out_code, out_last);
        end
        wait_drain("midrst");
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single_bit();
        test_multi_hot();
        test_backpressure();
        test_zero_enable();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
